// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared screen defaults, colour type and circle FSM encoding
//               for the VGA drawing blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int SCR_W_DFLT    = 160;
  localparam int SCR_H_DFLT    = 120;
  localparam int COLOUR_W_DFLT = 3;

  typedef logic [COLOUR_W_DFLT-1:0] colour_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    PLOT = 2'd2,
    DONE = 2'd3
  } circ_state_t;

endpackage
`default_nettype wire

// File: rtl/circle_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : circle_gen_if
// Description : Request/response and VGA write-port bundle of circle_gen.
//               master: sequencer side (drives start and operands)
//               slave : circle_gen side (drives done and the VGA write port)
//   start, centre_x, centre_y, radius, colour, octant_en : request operands
//   done                                                 : drawing complete
//   vga_x, vga_y, vga_colour, vga_plot                   : pixel write port
// Revision    : 1.0 - initial release
// ============================================================================
interface circle_gen_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic [X_W-1:0]      centre_x;
  logic [Y_W-1:0]      centre_y;
  logic [R_W-1:0]      radius;
  logic [COLOUR_W-1:0] colour;
  logic [7:0]          octant_en;
  logic                done;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  modport master (
    output start, centre_x, centre_y, radius, colour, octant_en,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, centre_x, centre_y, radius, colour, octant_en,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface
`default_nettype wire

// File: rtl/circle_octant_map.sv
`default_nettype none
// ============================================================================
// Module      : circle_octant_map
// Description : Combinational mapping of a first-octant offset (ox,oy) onto
//               one of the eight symmetric circle points around (cx,cy).
//   cx, cy  in  : centre
//   ox, oy  in  : Bresenham offsets
//   oct     in  : octant index 0..7
//   x, y    out : signed point, two guard bits wider than the screen field
// Revision    : 1.0 - initial release
// ============================================================================
module circle_octant_map #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int R_W = 8
) (
  input  logic [X_W-1:0]        cx,
  input  logic [Y_W-1:0]        cy,
  input  logic [R_W-1:0]        ox,
  input  logic [R_W-1:0]        oy,
  input  logic [2:0]            oct,
  output logic signed [X_W+1:0] x,
  output logic signed [Y_W+1:0] y
);

  logic signed [X_W+1:0] cx_s, ox_x, oy_x;
  logic signed [Y_W+1:0] cy_s, ox_y, oy_y;

  // Zero-extend everything into the signed working widths.
  assign cx_s = $signed({2'b00, cx});
  assign cy_s = $signed({2'b00, cy});
  assign ox_x = $signed({{(X_W+2-R_W){1'b0}}, ox});
  assign oy_x = $signed({{(X_W+2-R_W){1'b0}}, oy});
  assign ox_y = $signed({{(Y_W+2-R_W){1'b0}}, ox});
  assign oy_y = $signed({{(Y_W+2-R_W){1'b0}}, oy});

  always_comb begin
    x = cx_s;
    y = cy_s;
    case (oct)
      3'd0: begin x = cx_s + ox_x; y = cy_s + oy_y; end
      3'd1: begin x = cx_s + oy_x; y = cy_s + ox_y; end
      3'd2: begin x = cx_s - ox_x; y = cy_s + oy_y; end
      3'd3: begin x = cx_s - oy_x; y = cy_s + ox_y; end
      3'd4: begin x = cx_s - ox_x; y = cy_s - oy_y; end
      3'd5: begin x = cx_s - oy_x; y = cy_s - ox_y; end
      3'd6: begin x = cx_s + ox_x; y = cy_s - oy_y; end
      default: begin x = cx_s + oy_x; y = cy_s - ox_y; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/circle_gen.sv
`default_nettype none
// ============================================================================
// Module      : circle_gen
// Description : Bresenham circle/arc rasteriser, one pixel per clock, eight
//               octant points per step, per-octant enable and optional
//               screen clipping.
//   clk    in : system clock
//   rst_n  in : asynchronous active-low reset
//   bus       : circle_gen_if.slave (operands, done, VGA write port)
// Build option: define CIRCLE_GEN_CLIP_EN to suppress vga_plot for points
//               outside the SCR_W x SCR_H screen.
// Revision    : 1.0 - initial release
// ============================================================================
module circle_gen
  import vga_pkg::*;
#(
  parameter int SCR_W    = SCR_W_DFLT,
  parameter int SCR_H    = SCR_H_DFLT,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COLOUR_W = COLOUR_W_DFLT
) (
  input  logic         clk,
  input  logic         rst_n,
  circle_gen_if.slave  bus
);

`ifdef CIRCLE_GEN_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic signed [R_W+1:0] ONE     = (R_W+2)'(1);
  localparam logic signed [X_W+1:0] C_SCR_W = (X_W+2)'(SCR_W);
  localparam logic signed [Y_W+1:0] C_SCR_H = (Y_W+2)'(SCR_H);

  circ_state_t             state_q, state_d;
  logic [X_W-1:0]          cx_q, cx_d;
  logic [Y_W-1:0]          cy_q, cy_d;
  logic [R_W-1:0]          radius_q, radius_d;
  logic [COLOUR_W-1:0]     colour_q, colour_d;
  logic [7:0]              mask_q, mask_d;
  logic [R_W-1:0]          ox_q, ox_d;
  logic [R_W-1:0]          oy_q, oy_d;
  logic signed [R_W+1:0]   crit_q, crit_d;
  logic [2:0]              oct_q, oct_d;

  // Step arithmetic held in the wider signed domain so that ox may go to -1
  // (radius 0) and still end the circle after a single step.
  logic signed [R_W+1:0]   ox_ext, oy_nxt, ox_nxt, delta, crit_nxt;
  logic                    crit_pos;

  always_comb begin
    ox_ext   = $signed({2'b00, ox_q});
    oy_nxt   = $signed({2'b00, oy_q}) + ONE;
    crit_pos = !crit_q[R_W+1] && (crit_q != '0);
    ox_nxt   = crit_pos ? (ox_ext - ONE) : ox_ext;
    delta    = crit_pos ? (oy_nxt - ox_nxt) : oy_nxt;
    crit_nxt = crit_q + (delta <<< 1) + ONE;
  end

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    radius_d = radius_q;
    colour_d = colour_q;
    mask_d   = mask_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    crit_d   = crit_q;
    oct_d    = oct_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cx_d     = bus.centre_x;
          cy_d     = bus.centre_y;
          radius_d = bus.radius;
          colour_d = bus.colour;
          mask_d   = bus.octant_en;
          state_d  = INIT;
        end
      end
      INIT: begin
        ox_d    = radius_q;
        oy_d    = '0;
        crit_d  = ONE - $signed({2'b00, radius_q});
        oct_d   = 3'd0;
        state_d = PLOT;
      end
      PLOT: begin
        oct_d = oct_q + 3'd1;
        if (oct_q == 3'd7) begin
          ox_d   = ox_nxt[R_W-1:0];
          oy_d   = oy_nxt[R_W-1:0];
          crit_d = crit_nxt;
          if (oy_nxt > ox_nxt) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        if (!bus.start) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      radius_q <= '0;
      colour_q <= '0;
      mask_q   <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      crit_q   <= '0;
      oct_q    <= '0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      radius_q <= radius_d;
      colour_q <= colour_d;
      mask_q   <= mask_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      crit_q   <= crit_d;
      oct_q    <= oct_d;
    end
  end

  logic signed [X_W+1:0] pt_x;
  logic signed [Y_W+1:0] pt_y;
  logic                  in_plot, off_screen;

  circle_octant_map #(
    .X_W(X_W),
    .Y_W(Y_W),
    .R_W(R_W)
  ) u_map (
    .cx (cx_q),
    .cy (cy_q),
    .ox (ox_q),
    .oy (oy_q),
    .oct(oct_q),
    .x  (pt_x),
    .y  (pt_y)
  );

  assign in_plot    = (state_q == PLOT);
  assign off_screen = pt_x[X_W+1] || (pt_x >= C_SCR_W) ||
                      pt_y[Y_W+1] || (pt_y >= C_SCR_H);

  assign bus.done       = (state_q == DONE);
  assign bus.vga_x      = in_plot ? pt_x[X_W-1:0] : '0;
  assign bus.vga_y      = in_plot ? pt_y[Y_W-1:0] : '0;
  assign bus.vga_colour = colour_q;
  assign bus.vga_plot   = in_plot && mask_q[oct_q] && !(CLIP_EN && off_screen);

endmodule
`default_nettype wire

// File: tb/tb_circle_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_circle_gen
// Description : Self-checking bench for circle_gen: directed vector table,
//               hand-derived pixel lists, mid-draw reset and randomized
//               draws against a plain-arithmetic Bresenham model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_circle_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  circle_gen_if #(.X_W(8), .Y_W(7), .R_W(8), .COLOUR_W(3)) bus ();

  circle_gen dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int x;
    int y;
    bit p;
  } pix_t;

  pix_t exp_q[$];
  int   cap_x[$];
  int   cap_y[$];
  int   cap_p[$];

  typedef struct {
    int         cx;
    int         cy;
    int         r;
    logic [7:0] mask;
    bit         hold;
    int         exp_cycles;  // -1: not hand-derived
    int         exp_plots;   // -1: not hand-derived
  } vec_t;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  function automatic bit off_screen(input int px, input int py);
`ifdef CIRCLE_GEN_CLIP_EN
    return (px < 0) || (px >= 160) || (py < 0) || (py >= 120);
`else
    return 1'b0;
`endif
  endfunction

  // Textbook midpoint circle: enumerate 8 symmetric points per step.
  function automatic void build_model(input int cx, input int cy, input int r,
                                      input logic [7:0] m);
    int x, y, d, px, py;
    x = r; y = 0; d = 1 - r;
    exp_q.delete();
    do begin
      for (int k = 0; k < 8; k++) begin
        case (k)
          0: begin px = cx + x; py = cy + y; end
          1: begin px = cx + y; py = cy + x; end
          2: begin px = cx - x; py = cy + y; end
          3: begin px = cx - y; py = cy + x; end
          4: begin px = cx - x; py = cy - y; end
          5: begin px = cx - y; py = cy - x; end
          6: begin px = cx + x; py = cy - y; end
          default: begin px = cx + y; py = cy - x; end
        endcase
        exp_q.push_back('{px, py, m[k] && !off_screen(px, py)});
      end
      y++;
      if (d <= 0) d += 2 * y + 1;
      else begin
        x--;
        d += 2 * (y - x) + 1;
      end
    end while (y <= x);
  endfunction

  task automatic draw(input int cx, input int cy, input int r, input int col,
                      input logic [7:0] m, input bit hold,
                      output int cyc, output int nplot);
    build_model(cx, cy, r, m);
    cap_x.delete(); cap_y.delete(); cap_p.delete();
    @(negedge clk);
    bus.start     = 1'b1;
    bus.centre_x  = 8'(cx);
    bus.centre_y  = 7'(cy);
    bus.radius    = 8'(r);
    bus.colour    = 3'(col);
    bus.octant_en = m;
    @(negedge clk);
    chk("init_plot", int'(bus.vga_plot), 0);
    chk("init_done", int'(bus.done), 0);
    if (!hold) bus.start = 1'b0;
    // Operands are latched; later changes must be ignored.
    bus.centre_x  = 8'($urandom);
    bus.centre_y  = 7'($urandom);
    bus.radius    = 8'($urandom);
    bus.colour    = 3'($urandom);
    bus.octant_en = 8'($urandom);
    cyc = 0; nplot = 0;
    forever begin
      @(negedge clk);
      if (bus.done || cyc >= 4000) break;
      cap_x.push_back(int'(bus.vga_x));
      cap_y.push_back(int'(bus.vga_y));
      cap_p.push_back(int'(bus.vga_plot));
      if (bus.vga_plot) nplot++;
      if (cyc < exp_q.size()) begin
        chk("pix_x", int'(bus.vga_x), exp_q[cyc].x & 255);
        chk("pix_y", int'(bus.vga_y), exp_q[cyc].y & 127);
        chk("pix_plot", int'(bus.vga_plot), int'(exp_q[cyc].p));
        chk("pix_colour", int'(bus.vga_colour), col);
      end
      cyc++;
    end
    chk("plot_cycles", cyc, exp_q.size());
    chk("done_rise", int'(bus.done), 1);
    chk("done_plot", int'(bus.vga_plot), 0);
    if (hold) begin
      @(negedge clk);
      chk("done_held", int'(bus.done), 1);
      bus.start = 1'b0;
    end
    @(negedge clk);
    chk("done_fall", int'(bus.done), 0);
  endtask

  vec_t vecs[6];
  int   r1x[16];
  int   r1y[16];

  initial begin
    int cyc, np;

    vecs[0] = '{80, 60, 0, 8'hFF, 1'b0,  8,  8};
    vecs[1] = '{80, 60, 1, 8'hFF, 1'b0, 16, 16};
    vecs[2] = '{80, 60, 1, 8'h01, 1'b0, 16,  2};
    vecs[3] = '{80, 60, 2, 8'hFF, 1'b1, 16, 16};
    vecs[4] = '{50, 40, 3, 8'h0F, 1'b0, 24, 12};
    vecs[5] = '{ 2, 60, 5, 8'hFF, 1'b0, 32, -1};
    r1x = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
    r1y = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};

    bus.start = 1'b0; bus.centre_x = '0; bus.centre_y = '0;
    bus.radius = '0; bus.colour = '0; bus.octant_en = '0;

    repeat (2) @(negedge clk);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_plot", int'(bus.vga_plot), 0);
    chk("rst_x", int'(bus.vga_x), 0);
    chk("rst_y", int'(bus.vga_y), 0);
    chk("rst_colour", int'(bus.vga_colour), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      draw(vecs[v].cx, vecs[v].cy, vecs[v].r, v + 1, vecs[v].mask, vecs[v].hold, cyc, np);
      if (vecs[v].exp_cycles >= 0) chk("vec_cycles", cyc, vecs[v].exp_cycles);
      if (vecs[v].exp_plots >= 0) chk("vec_plots", np, vecs[v].exp_plots);
      if (v == 1) begin
        for (int i = 0; i < 16 && i < cap_x.size(); i++) begin
          chk("r1_x", cap_x[i], r1x[i]);
          chk("r1_y", cap_y[i], r1y[i]);
        end
      end
      if (v == 2 && cap_p.size() >= 9) begin
        chk("mask01_c1", cap_p[0], 1);
        chk("mask01_c9", cap_p[8], 1);
        chk("mask01_x9", cap_x[8], 81);
        chk("mask01_y9", cap_y[8], 61);
      end
      if (v == 5 && cap_p.size() >= 3) begin
        chk("clip_x", cap_x[2], 253);
`ifdef CIRCLE_GEN_CLIP_EN
        chk("clip_plot", cap_p[2], 0);
`else
        chk("clip_plot", cap_p[2], 1);
`endif
      end
    end

    // Asynchronous reset in the middle of an r=10 draw.
    @(negedge clk);
    bus.start = 1'b1; bus.centre_x = 8'd80; bus.centre_y = 7'd60;
    bus.radius = 8'd10; bus.colour = 3'd5; bus.octant_en = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_plot_before", int'(bus.vga_plot), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_plot", int'(bus.vga_plot), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_x", int'(bus.vga_x), 0);
    chk("mid_rst_colour", int'(bus.vga_colour), 0);
    @(negedge clk);
    rst_n = 1'b1;
    draw(80, 60, 2, 6, 8'hFF, 1'b0, cyc, np);
    chk("post_rst_cycles", cyc, 16);

    // Randomized draws against the model.
    for (int t = 0; t < 12; t++) begin
      draw($urandom_range(0, 255), $urandom_range(0, 119), $urandom_range(0, 40),
           $urandom_range(0, 7), 8'($urandom), 1'($urandom_range(0, 1)), cyc, np);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
